// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums N_ELEM signed lanes over a group of beats with
// per-lane saturation, then holds the result until the downstream handshake.
module psum_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int N_ELEM     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_ELEM*DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_ELEM*DATA_WIDTH-1:0] out_data,
    output logic [N_ELEM-1:0]            out_sat,
    output logic [CNT_WIDTH-1:0]         beat_cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic                   first_reg;
    logic                   first_next;
    logic [CNT_WIDTH-1:0]   beat_cnt_reg;
    logic [CNT_WIDTH-1:0]   beat_cnt_next;
    logic                   accept;
    logic                   handshake;
    logic                   is_first;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    // A beat taken in the same cycle as the output handshake opens a new group.
    assign is_first  = first_reg || handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM: begin
                if (accept && in_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = (accept && in_last) ? HOLD : ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        out_valid = (state_reg == HOLD);
        in_ready  = (state_reg == ACCUM) || out_ready;
    end

    always_comb begin
        first_next    = first_reg;
        beat_cnt_next = beat_cnt_reg;
        if (accept) begin
            first_next = in_last ? is_first : 1'b0;
            if (is_first) begin
                beat_cnt_next = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (!(&beat_cnt_reg)) begin
                beat_cnt_next = beat_cnt_reg + 1'b1;
            end
        end else if (handshake) begin
            first_next    = 1'b1;
            beat_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_reg    <= 1'b1;
            beat_cnt_reg <= '0;
        end else begin
            first_reg    <= first_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    assign beat_cnt = beat_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_ELEM; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] acc_reg;
            logic                  sat_reg;
            logic [DATA_WIDTH-1:0] lane;
            logic [DATA_WIDTH:0]   sum_ext;
            logic                  ovf;
            logic [DATA_WIDTH-1:0] sum_sat;

            assign lane    = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sum_ext = {acc_reg[DATA_WIDTH-1], acc_reg} + {lane[DATA_WIDTH-1], lane};
            // Sign bits disagree exactly when the true sum left the DATA_WIDTH range.
            assign ovf     = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
            assign sum_sat = !ovf ? sum_ext[DATA_WIDTH-1:0] :
                             sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                                   {1'b0, {(DATA_WIDTH-1){1'b1}}};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                    sat_reg <= 1'b0;
                end else if (accept) begin
                    if (is_first) begin
                        acc_reg <= lane;
                        sat_reg <= 1'b0;
                    end else begin
                        acc_reg <= sum_sat;
                        sat_reg <= sat_reg | ovf;
                    end
                end
            end

            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = acc_reg;
            assign out_sat[gi]                           = sat_reg;
        end
    endgenerate

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: table of per-cycle vectors plus a
// hand-written mid-group reset sequence.
module tb_psum_accumulator;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_sat;
    logic [15:0]  beat_cnt;

    int checks = 0;
    int errors = 0;

    psum_accumulator #(
        .DATA_WIDTH(32),
        .N_ELEM    (4),
        .CNT_WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .beat_cnt (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic         last;
        logic         ordy;
        logic [127:0] d;
        logic         exp_ir;
        logic         exp_ov;
        logic [127:0] exp_d;
        logic [3:0]   exp_sat;
        logic [15:0]  exp_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic logic [127:0] pk(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(input logic v, input logic last, input logic ordy,
                                input logic [127:0] d, input logic exp_ir,
                                input logic exp_ov, input logic [127:0] exp_d,
                                input logic [3:0] exp_sat, input logic [15:0] exp_cnt);
        vec_t r;
        r.v = v; r.last = last; r.ordy = ordy; r.d = d;
        r.exp_ir = exp_ir; r.exp_ov = exp_ov; r.exp_d = exp_d;
        r.exp_sat = exp_sat; r.exp_cnt = exp_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic last, input logic ordy, input logic [127:0] d);
        in_valid  = v;
        in_last   = last;
        out_ready = ordy;
        in_data   = d;
    endtask

    logic [127:0] held;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);

        // 3-beat group: lane0 sum, lane1 positive clamp, lane2 negative clamp
        vt.push_back(mk(1, 0, 1, pk(10, 32'h7FFFFFF0, 32'h80000000, 5), 1, 0,
                        pk(10, 32'h7FFFFFF0, 32'h80000000, 5), 4'b0000, 1));
        vt.push_back(mk(1, 0, 1, pk(20, 32'h20, 32'hFFFFFFFF, 6), 1, 0,
                        pk(30, 32'h7FFFFFFF, 32'h80000000, 11), 4'b0110, 2));
        vt.push_back(mk(1, 1, 1, pk(-5, 0, 0, 0), 1, 1,
                        pk(25, 32'h7FFFFFFF, 32'h80000000, 11), 4'b0110, 3));
        held = pk(25, 32'h7FFFFFFF, 32'h80000000, 11);
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(1, 1, 0, pk(99, 99, 99, 99), 0, 1, held, 4'b0110, 3));
        // Release: handshake plus new first beat in the same cycle, sat cleared
        vt.push_back(mk(1, 0, 1, pk(1, 2, 3, 4), 1, 0, pk(1, 2, 3, 4), 4'b0000, 1));
        vt.push_back(mk(1, 1, 1, pk(7, 7, 7, 7), 1, 1, pk(8, 9, 10, 11), 4'b0000, 2));
        // Back-to-back single-beat groups
        vt.push_back(mk(1, 1, 1, pk(100, 200, 300, 400), 1, 1, pk(100, 200, 300, 400), 4'b0000, 1));
        vt.push_back(mk(1, 1, 1, pk(-1, -2, -3, -4), 1, 1, pk(-1, -2, -3, -4), 4'b0000, 1));
        vt.push_back(mk(0, 0, 1, '0, 1, 0, pk(-1, -2, -3, -4), 4'b0000, 0));
        vt.push_back(mk(0, 0, 0, '0, 1, 0, pk(-1, -2, -3, -4), 4'b0000, 0));
        // Negative saturation on lane0 only
        vt.push_back(mk(1, 0, 0, pk(32'h80000001, 1, 2, 3), 1, 0,
                        pk(32'h80000001, 1, 2, 3), 4'b0000, 1));
        vt.push_back(mk(1, 1, 0, pk(32'hFFFFFFFB, 1, 1, 1), 1, 1,
                        pk(32'h80000000, 2, 3, 4), 4'b0001, 2));
        vt.push_back(mk(0, 0, 1, '0, 1, 0, pk(32'h80000000, 2, 3, 4), 4'b0001, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst out_data", out_data, 0);
        check("rst out_sat", out_sat, 0);
        check("rst beat_cnt", beat_cnt, 0);
        $display("reset: ov=%0b ir=%0b cnt=%0d", out_valid, in_ready, beat_cnt);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vt[k]) begin
            drive(vt[k].v, vt[k].last, vt[k].ordy, vt[k].d);
            #1;
            check($sformatf("v%0d in_ready", k), in_ready, vt[k].exp_ir);
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", k), out_valid, vt[k].exp_ov);
            check($sformatf("v%0d out_data", k), out_data, vt[k].exp_d);
            check($sformatf("v%0d out_sat", k), out_sat, vt[k].exp_sat);
            check($sformatf("v%0d beat_cnt", k), beat_cnt, vt[k].exp_cnt);
            $display("vec %0d: v=%0b last=%0b ordy=%0b ov=%0b data=%h sat=%b cnt=%0d",
                     k, vt[k].v, vt[k].last, vt[k].ordy, out_valid, out_data, out_sat, beat_cnt);
            @(negedge clk);
        end

        // Reset after two beats of a three-beat group
        drive(1, 0, 1, pk(1, 1, 1, 1));
        @(negedge clk);
        drive(1, 0, 1, pk(2, 2, 2, 2));
        @(posedge clk);
        #2;
        check("pre-rst beat_cnt", beat_cnt, 2);
        check("pre-rst out_data", out_data, pk(3, 3, 3, 3));
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst out_data", out_data, 0);
        check("async rst beat_cnt", beat_cnt, 0);
        $display("mid-group reset: ov=%0b data=%h cnt=%0d", out_valid, out_data, beat_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 1, pk(7, 0, 0, 0));
        @(posedge clk);
        #1;
        check("post-rst first beat_cnt", beat_cnt, 1);
        check("post-rst first data", out_data, pk(7, 0, 0, 0));
        @(negedge clk);
        drive(1, 1, 0, pk(8, 0, 0, 0));
        @(posedge clk);
        #1;
        check("post-rst group out_valid", out_valid, 1);
        check("post-rst group data", out_data, pk(15, 0, 0, 0));
        check("post-rst group beat_cnt", beat_cnt, 2);
        check("post-rst group sat", out_sat, 0);
        $display("post-reset group: ov=%0b data=%h cnt=%0d", out_valid, out_data, beat_cnt);
        @(negedge clk);
        drive(0, 0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
